// File: rtl/add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_stage
// Description : AES AddRoundKey pipeline stage. XORs the state with the key
//               selected by its round tag, output behind a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_stage #(
    parameter int NUM_KEYS = 11,
    parameter int RW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [RW-1:0] key_idx,
    input  logic [127:0]  key_data,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [127:0]  state_i,
    input  logic [RW-1:0] round_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [127:0]  state_o,
    output logic [RW-1:0] round_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    logic [127:0]        r_keys [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_loaded;
    logic [NUM_KEYS-1:0] w_wsel;

    logic [127:0]        w_key;
    logic                w_hit;
    logic                w_accept;
    logic [127:0]        w_result;

    skid_state_t         r_state;
    logic                r_valid;
    logic                r_ready;
    logic [127:0]        r_main_state;
    logic [RW-1:0]       r_main_round;
    logic [127:0]        r_skid_state;
    logic [RW-1:0]       r_skid_round;
    logic                r_err;

    // An out-of-range index matches no entry, so such writes fall away.
    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_sel
            assign w_wsel[g] = key_we && (key_idx == RW'(g));
        end
    endgenerate

    // Table contents need no reset; the loaded bits gate every use.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_wsel[k]) begin
                r_keys[k] <= key_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loaded <= '0;
        end else begin
            r_loaded <= r_loaded | w_wsel;
        end
    end

    // Reads the registered table, so a same-cycle write is not yet visible.
    always_comb begin
        w_key = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if ((round_i == RW'(k)) && r_loaded[k]) begin
                w_key = r_keys[k];
                w_hit = 1'b1;
            end
        end
    end

    assign w_accept = valid_i && r_ready;
    assign w_result = state_i ^ w_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_err <= 1'b1;
        end
    end

    // ready_o is a register so no combinational path runs from ready_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_valid      <= 1'b0;
            r_ready      <= 1'b0;
            r_main_state <= '0;
            r_main_round <= '0;
            r_skid_state <= '0;
            r_skid_round <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_main_state <= w_result;
                        r_main_round <= round_i;
                        r_valid      <= 1'b1;
                        r_state      <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && ready_i) begin
                        r_main_state <= w_result;
                        r_main_round <= round_i;
                    end else if (w_accept) begin
                        r_skid_state <= w_result;
                        r_skid_round <= round_i;
                        r_ready      <= 1'b0;
                        r_state      <= S_FULL;
                    end else if (ready_i) begin
                        r_valid      <= 1'b0;
                        r_state      <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (ready_i) begin
                        r_main_state <= r_skid_state;
                        r_main_round <= r_skid_round;
                        r_ready      <= 1'b1;
                        r_state      <= S_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign state_o = r_main_state;
    assign round_o = r_main_round;
    assign err_o   = r_err;

endmodule
`default_nettype wire
